// File: rtl/riscv_div_unit_pkg.sv
// Shared types for the RV32M iterative divider: op encoding (funct3[1:0]) and FSM states.
package riscv_div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_S   = 2'b00,
    DIVU_OP = 2'b01,
    REM_S   = 2'b10,
    REMU_OP = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  function automatic logic op_is_signed(input div_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/riscv_div_negate.sv
// Combinational conditional two's-complement negate.
module riscv_div_negate #(
  parameter int N = 32
) (
  input  logic         neg,
  input  logic [N-1:0] a,
  output logic [N-1:0] y
);

  // y = -a when neg is set, otherwise a unchanged
  always_comb begin
    y = a;
    if (neg) begin
      y = ~a + N'(1);
    end else begin
      y = a;
    end
  end

endmodule

// File: rtl/riscv_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; stalls EX through busy_o.
module riscv_div_unit
  import riscv_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);

  div_state_t      state_r;
  div_op_t         op_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quot_r;
  logic [XLEN-1:0] dvs_r;
  logic            neg_q_r;
  logic            neg_r_r;
  logic            busy_r;
  logic            done_r;
  logic [XLEN-1:0] result_r;

  div_op_t         op_in_s;
  logic            neg_a_s;
  logic            neg_b_s;
  logic [XLEN-1:0] abs_a_s;
  logic [XLEN-1:0] abs_b_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic [XLEN-1:0] special_res_s;
  logic [XLEN:0]   shift_s;
  logic [XLEN:0]   trial_s;
  logic [XLEN-1:0] q_fix_s;
  logic [XLEN-1:0] r_fix_s;
  logic [XLEN-1:0] fix_res_s;

  assign op_in_s    = div_op_t'(op_i);
  assign neg_a_s    = op_is_signed(op_in_s) & dividend_i[XLEN-1];
  assign neg_b_s    = op_is_signed(op_in_s) & divisor_i[XLEN-1];
  assign div_zero_s = (divisor_i == {XLEN{1'b0}});
  assign ovf_s      = op_is_signed(op_in_s)
                    & (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                    & (divisor_i == {XLEN{1'b1}});

  riscv_div_negate #(.N(XLEN)) u_abs_a (.neg(neg_a_s), .a(dividend_i), .y(abs_a_s));
  riscv_div_negate #(.N(XLEN)) u_abs_b (.neg(neg_b_s), .a(divisor_i),  .y(abs_b_s));
  riscv_div_negate #(.N(XLEN)) u_fix_q (.neg(neg_q_r), .a(quot_r),     .y(q_fix_s));
  riscv_div_negate #(.N(XLEN)) u_fix_r (.neg(neg_r_r), .a(rem_r),      .y(r_fix_s));

  // Architectural results for divide-by-zero and signed overflow, bypassing iteration
  always_comb begin
    special_res_s = {XLEN{1'b0}};
    if (div_zero_s) begin
      special_res_s = op_is_rem(op_in_s) ? dividend_i : {XLEN{1'b1}};
    end else if (ovf_s) begin
      special_res_s = op_is_rem(op_in_s) ? {XLEN{1'b0}} : dividend_i;
    end else begin
      special_res_s = {XLEN{1'b0}};
    end
  end

  // One restoring step: the shifted partial remainder needs XLEN+1 bits before the trial subtract
  always_comb begin
    shift_s = {1'b0, rem_r, quot_r[XLEN-1]};
    trial_s = shift_s - {1'b0, dvs_r};
  end

  // Pick quotient or remainder after sign fix-up
  always_comb begin
    fix_res_s = q_fix_s;
    case (op_r)
      DIV_S, DIVU_OP: fix_res_s = q_fix_s;
      REM_S, REMU_OP: fix_res_s = r_fix_s;
      default:        fix_res_s = q_fix_s;
    endcase
  end

  // Divider FSM with datapath and registered busy/done/result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      op_r     <= DIV_S;
      cnt_r    <= {CNT_W{1'b0}};
      rem_r    <= {XLEN{1'b0}};
      quot_r   <= {XLEN{1'b0}};
      dvs_r    <= {XLEN{1'b0}};
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start_i && !flush_i) begin
            op_r    <= op_in_s;
            neg_q_r <= neg_a_s ^ neg_b_s;
            neg_r_r <= neg_a_s;
            cnt_r   <= {CNT_W{1'b0}};
            rem_r   <= {XLEN{1'b0}};
            quot_r  <= abs_a_s;
            dvs_r   <= abs_b_s;
            busy_r  <= 1'b1;
            if (div_zero_s || ovf_s) begin
              result_r <= special_res_s;
              done_r   <= 1'b1;
              state_r  <= DONE;
            end else begin
              state_r  <= CALC;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        CALC: begin
          if (flush_i) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            // A non-negative trial result keeps the subtraction and sets the quotient bit
            if (!trial_s[XLEN]) begin
              rem_r  <= trial_s[XLEN-1:0];
              quot_r <= {quot_r[XLEN-2:0], 1'b1};
            end else begin
              rem_r  <= shift_s[XLEN-1:0];
              quot_r <= {quot_r[XLEN-2:0], 1'b0};
            end
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == CNT_W'(XLEN-1)) begin
              state_r <= FIX;
            end else begin
              state_r <= CALC;
            end
          end
        end
        FIX: begin
          if (flush_i) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            result_r <= fix_res_s;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign result_o = result_r;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Self-checking bench for riscv_div_unit: cycle-level reference model plus directed vectors.
module tb_riscv_div_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  riscv_div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Model: an accepted op is busy for lat cycles and shows its result from the done cycle on
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 0;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_shown = 32'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  = 1'b0;
      m_cnt   = 0;
      m_shown = 32'd0;
    end else if (!m_busy) begin
      if (start_i && !flush_i) begin
        m_busy = 1'b1;
        m_cnt  = 1;
        m_lat  = ref_lat(op_i, dividend_i, divisor_i);
        m_res  = ref_result(op_i, dividend_i, divisor_i);
        if (m_cnt == m_lat) m_shown = m_res;
      end
    end else if (flush_i || m_cnt == m_lat) begin
      m_busy = 1'b0;
    end else begin
      m_cnt++;
      if (m_cnt == m_lat) m_shown = m_res;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc busy", {31'd0, busy_o}, {31'd0, m_busy});
      check("cyc done", {31'd0, done_o}, {31'd0, (m_busy && m_cnt == m_lat)});
      check("cyc result", result_o, m_shown);
    end
  end

  // Issue one op; flush_at>0 aborts in that cycle and then exp is the held result
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input int flush_at, input int pulse_at);
    int n;
    bit got;
    op_i = op;
    dividend_i = a;
    divisor_i = b;
    start_i = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      start_i = (n == pulse_at);
      op_i = 2'($urandom_range(0, 3));
      dividend_i = $urandom;
      divisor_i = $urandom;
      flush_i = (n == flush_at);
      if (flush_at > 0 && n == flush_at + 1) begin
        check({name, " flush busy"}, {31'd0, busy_o}, 32'd0);
        check({name, " flush done"}, {31'd0, done_o}, 32'd0);
        check({name, " flush held"}, result_o, exp);
        return;
      end
      got = done_o;
    end
    check({name, " latency"}, 32'(n), 32'(exp_lat));
    check({name, " result"}, result_o, exp);
    start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset_n = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i = 2'b00;
    dividend_i = 32'd0;
    divisor_i = 32'd0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset done", {31'd0, done_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 34, 0, 0);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 34, 0, 0);
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0, 0);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0, 0);
    run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 0, 0);
    run_op("div 5/0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
    run_op("rem 5/0", 2'b10, 32'd5, 32'd0, 32'd5, 1, 0, 0);
    run_op("divu max/max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 34, 0, 0);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 0);
    run_op("divu ovf ops", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 0, 0);
    run_op("divu 77/7", 2'b01, 32'd77, 32'd7, 32'd11, 34, 0, 0);
    run_op("flush divu", 2'b01, 32'd1000, 32'd10, 32'd11, 0, 10, 0);
    run_op("restart divu", 2'b01, 32'd1000, 32'd10, 32'd100, 34, 0, 0);
    run_op("div -100/7 pulse", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 0, 5);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i < 2) ? $urandom : 32'($urandom_range(1, 300));
      run_op("rand", rop, ra, rb, ref_result(rop, ra, rb), ref_lat(rop, ra, rb), 0, 0);
    end

    op_i = 2'b01;
    dividend_i = 32'd1000;
    divisor_i = 32'd3;
    start_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("midreset busy", {31'd0, busy_o}, 32'd0);
    check("midreset done", {31'd0, done_o}, 32'd0);
    check("midreset result", result_o, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_op("divu 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 34, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
